expiry_alarm: RTL and testbench



---
 rtl/countdown_pkg.sv | 28 ++
 rtl/expiry_alarm_tone_gen.sv | 36 +++
 rtl/expiry_alarm.sv | 125 ++++++++++++
 tb/tb_expiry_alarm.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/countdown_pkg.sv
// Shared state encoding and cycle-count helpers for the countdown alert path.
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CHIRP     = 2'd1,
        ALARM_ON  = 2'd2,
        ALARM_OFF = 2'd3
    } state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << r) < 64'(n)) r = r + 1;
        end
        return r;
    endfunction

    function automatic int ms_to_cyc(input int clk_hz, input int ms);
        return clk_hz / 1000 * ms;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/expiry_alarm_tone_gen.sv
// Buzzer square-wave divider: starts high on restart, toggles every HALF cycles while enabled.
module tone_gen
    import countdown_pkg::*;
#(
    parameter int HALF = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic restart,
    output logic tone
);

    localparam int TW = (clog2(HALF) < 1) ? 1 : clog2(HALF);

    logic [TW-1:0] cnt_q;
    logic          tone_q;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt_q  <= '0;
            tone_q <= 1'b0;
        end else if (restart) begin
            cnt_q  <= '0;
            tone_q <= 1'b1;
        end else if (cnt_q == TW'(HALF - 1)) begin
            cnt_q  <= '0;
            tone_q <= ~tone_q;
        end else begin
            cnt_q  <= cnt_q + TW'(1);
        end
    end

    assign tone = tone_q;

endmodule

// File: rtl/expiry_alarm.sv
// Alert stage: warning chirps near the end of a run and a patterned alarm on expiry.
module expiry_alarm
    import countdown_pkg::*;
#(
    parameter int CLK_HZ      = 10_000_000,
    parameter int TONE_HZ     = 2000,
    parameter int BEEP_MS     = 250,
    parameter int CHIRP_MS    = 50,
    parameter int ALARM_BEEPS = 5,
    parameter int WARN_SECS   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] seconds,
    input  logic       running,
    input  logic       ack_p,
    output logic       buzzer,
    output logic       alarm_led,
    output logic       alarm_active
);

    localparam int HALF      = CLK_HZ / (2 * TONE_HZ);
    localparam int BEEP_CYC  = ms_to_cyc(CLK_HZ, BEEP_MS);
    localparam int CHIRP_CYC = ms_to_cyc(CLK_HZ, CHIRP_MS);
    localparam int TMR_MAX   = max2(BEEP_CYC, CHIRP_CYC);
    localparam int TMR_W     = (clog2(TMR_MAX) < 1) ? 1 : clog2(TMR_MAX);
    localparam int BCNT_W    = (clog2(ALARM_BEEPS + 1) < 1) ? 1 : clog2(ALARM_BEEPS + 1);

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [BCNT_W-1:0]  bcnt_q, bcnt_d;
    logic               running_q;
    logic [5:0]         seconds_q;
    logic               led_q, active_q;
    logic               phase_start;
    logic               expiry, warn, restart;
    logic               sounding_d;

    assign expiry  = running_q & ~running & (seconds == 6'd0);
    assign warn    = running & (seconds != seconds_q) &
                     (seconds >= 6'd1) & (seconds <= 6'(WARN_SECS));
    assign restart = running & ~running_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            bcnt_q    <= '0;
            running_q <= 1'b0;
            seconds_q <= '0;
            led_q     <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bcnt_q    <= bcnt_d;
            running_q <= running;
            seconds_q <= seconds;
            led_q     <= (state_d == ALARM_ON);
            active_q  <= (state_d == ALARM_ON) || (state_d == ALARM_OFF);
        end
    end

    // phase_start marks every (re)entry into a timed phase so the tone restarts with it.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q + TMR_W'(1);
        bcnt_d      = bcnt_q;
        phase_start = 1'b0;
        if (expiry) begin
            state_d     = ALARM_ON;
            timer_d     = '0;
            bcnt_d      = BCNT_W'(1);
            phase_start = 1'b1;
        end else begin
            case (state_q)
                ALARM_ON, ALARM_OFF: begin
                    if (ack_p || restart) begin
                        state_d = IDLE;
                        timer_d = '0;
                        bcnt_d  = '0;
                    end else if (timer_q == TMR_W'(BEEP_CYC - 1)) begin
                        timer_d = '0;
                        if (state_q == ALARM_ON) begin
                            state_d = ALARM_OFF;
                        end else if (bcnt_q < BCNT_W'(ALARM_BEEPS)) begin
                            state_d     = ALARM_ON;
                            bcnt_d      = bcnt_q + BCNT_W'(1);
                            phase_start = 1'b1;
                        end else begin
                            state_d = IDLE;
                            bcnt_d  = '0;
                        end
                    end
                end
                default: begin
                    if (warn) begin
                        state_d     = CHIRP;
                        timer_d     = '0;
                        phase_start = 1'b1;
                    end else if (state_q == CHIRP && timer_q == TMR_W'(CHIRP_CYC - 1)) begin
                        state_d = IDLE;
                        timer_d = '0;
                    end else if (state_q == IDLE) begin
                        timer_d = '0;
                    end
                end
            endcase
        end
    end

    assign sounding_d = (state_d == CHIRP) || (state_d == ALARM_ON);

    tone_gen #(.HALF(HALF)) u_tone (
        .clk     (clk),
        .rst     (rst),
        .en      (sounding_d),
        .restart (phase_start),
        .tone    (buzzer)
    );

    assign alarm_led    = led_q;
    assign alarm_active = active_q;

endmodule

// File: tb/tb_expiry_alarm.sv
// Bench for expiry_alarm: directed scenarios plus random traffic against a time-based reference model.
module tb_expiry_alarm;

    localparam int H = 5;
    localparam int B = 100;
    localparam int C = 20;
    localparam int N = 3;
    localparam int W = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] seconds;
    logic       running;
    logic       ack_p;
    logic       buzzer, alarm_led, alarm_active;

    always #5 clk = ~clk;

    expiry_alarm #(
        .CLK_HZ(10000), .TONE_HZ(1000), .BEEP_MS(10), .CHIRP_MS(2),
        .ALARM_BEEPS(N), .WARN_SECS(W)
    ) dut (
        .clk(clk), .rst(rst), .seconds(seconds), .running(running), .ack_p(ack_p),
        .buzzer(buzzer), .alarm_led(alarm_led), .alarm_active(alarm_active)
    );

    int checks = 0;
    int failures = 0;

    // Reference: an alarm or chirp is a timestamped episode; outputs follow from elapsed time.
    bit         m_alarm, m_chirp;
    int         m_alarm_t, m_chirp_t;
    bit         m_prev_run;
    int         m_prev_sec;
    bit         e_buz, e_led, e_act;

    int act_cnt, led_cnt, buz_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit was_alarm, ev_exp, ev_warn, ev_rs;
        if (rst) begin
            m_alarm = 0; m_chirp = 0; m_alarm_t = 0; m_chirp_t = 0;
            m_prev_run = 0; m_prev_sec = 0;
        end else begin
            ev_exp  = m_prev_run && !running && (seconds == 0);
            ev_warn = running && (int'(seconds) != m_prev_sec) && (seconds >= 1) && (seconds <= W);
            ev_rs   = running && !m_prev_run;
            was_alarm = m_alarm;
            if (m_alarm) begin
                m_alarm_t++;
                if (m_alarm_t >= 2 * B * N) m_alarm = 0;
            end
            if (m_chirp) begin
                m_chirp_t++;
                if (m_chirp_t >= C) m_chirp = 0;
            end
            if (ev_exp) begin
                m_alarm = 1; m_alarm_t = 0; m_chirp = 0;
            end else if (was_alarm && (ack_p || ev_rs)) begin
                m_alarm = 0;
            end else if (!was_alarm && ev_warn) begin
                m_chirp = 1; m_chirp_t = 0;
            end
            m_prev_run = running;
            m_prev_sec = int'(seconds);
        end
        e_act = m_alarm;
        e_led = m_alarm && ((m_alarm_t / B) % 2 == 0);
        if (m_alarm)      e_buz = e_led && (((m_alarm_t % B) / H) % 2 == 0);
        else if (m_chirp) e_buz = ((m_chirp_t / H) % 2 == 0);
        else              e_buz = 0;
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_edge();
            #1;
            check("buzzer", 32'(buzzer), 32'(e_buz));
            check("alarm_led", 32'(alarm_led), 32'(e_led));
            check("alarm_active", 32'(alarm_active), 32'(e_act));
            act_cnt += int'(alarm_active);
            led_cnt += int'(alarm_led);
            buz_cnt += int'(buzzer);
        end
    endtask

    initial begin
        int r;
        act_cnt = 0; led_cnt = 0; buz_cnt = 0;
        rst = 1; running = 1'($urandom); seconds = 6'($urandom_range(0, 59)); ack_p = 1'($urandom);
        step(3);
        check("rst_buzzer", 32'(buzzer), 32'd0);
        check("rst_led", 32'(alarm_led), 32'd0);
        check("rst_active", 32'(alarm_active), 32'd0);
        rst = 0; running = 0; seconds = 0; ack_p = 0;
        step(2);

        // warning chirps: only seconds=3 sounds, 10 high cycles over 20
        running = 1; seconds = 5; step(100);
        seconds = 4; step(100);
        check("no_chirp_5_4", 32'(buz_cnt), 32'd0);
        seconds = 3; buz_cnt = 0; act_cnt = 0; step(100);
        check("chirp_hi_cycles", 32'(buz_cnt), 32'd10);
        check("chirp_no_active", 32'(act_cnt), 32'd0);
        seconds = 2; step(100);
        seconds = 1; step(100);

        // full alarm train
        seconds = 0; running = 0; act_cnt = 0; led_cnt = 0; buz_cnt = 0;
        step(700);
        check("train_active_len", 32'(act_cnt), 32'd600);
        check("train_led_len", 32'(led_cnt), 32'd300);
        check("train_buz_hi", 32'(buz_cnt), 32'd150);

        // acknowledge in an off-phase, then stray acks
        running = 1; seconds = 1; step(10);
        seconds = 0; running = 0; step(150);
        check("ack_pre_off", 32'(alarm_led), 32'd0);
        ack_p = 1; step(1); ack_p = 0;
        check("ack_active", 32'(alarm_active), 32'd0);
        step(20); ack_p = 1; step(1); ack_p = 0; step(5);
        check("ack_late", 32'(alarm_active), 32'd0);

        // expiry with ack in the same cycle still alarms
        running = 1; seconds = 1; step(5);
        seconds = 0; running = 0; ack_p = 1; step(1); ack_p = 0;
        check("exp_ack_active", 32'(alarm_active), 32'd1);
        step(30);

        // restart during alarm, then pause at 7, then reset mid-chirp
        running = 1; seconds = 59; step(1);
        check("restart_idle", 32'(alarm_active), 32'd0);
        seconds = 7; step(5); running = 0; act_cnt = 0; step(50);
        check("pause_no_alarm", 32'(act_cnt), 32'd0);
        seconds = 6; step(10);
        running = 1; seconds = 3; step(3);
        rst = 1; step(1);
        check("rst_mid_chirp", 32'(buzzer), 32'd0);
        rst = 0; step(5);

        // random traffic
        for (int i = 0; i < 6000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 3 && running) begin
                if (seconds == 0) running = 0;
                else seconds = seconds - 6'd1;
            end else if (r < 3 && !running && $urandom_range(0, 3) == 0) begin
                running = 1; seconds = 6'($urandom_range(0, 8));
            end else if (r == 3 && $urandom_range(0, 3) == 0) begin
                running = ~running;
            end else if (r == 4 && $urandom_range(0, 3) == 0) begin
                seconds = 6'($urandom_range(0, 59));
            end
            ack_p = ($urandom_range(0, 299) == 0);
            rst   = ($urandom_range(0, 1999) == 0);
            step(1);
        end
        rst = 0; ack_p = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
